// File: rtl/riscv_definitions.sv
// Shared core-wide widths and the writeback request record.
package riscv_definitions;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR   = 5;

    typedef struct packed {
        logic [REG_ADDR-1:0]   rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_LSU  = 2'd2
    } wb_grant_e;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO for load results waiting for a writeback slot.
module wb_fifo
    import riscv_definitions::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_push,
    input  wb_req_t i_push_data,
    input  logic    i_pop,
    output wb_req_t o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Extra top bit separates full from empty when the index bits match.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    wb_req_t        mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: non-blocking so every register in the edge samples pre-edge values.
            if (i_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (i_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // NOTE: storage has no reset; the pointers alone say which entries are valid.
    always_ff @(posedge i_clk) begin
        if (i_push) mem[wr_ptr[PTR_W-1:0]] <= i_push_data;
    end

    assign o_head  = mem[rd_ptr[PTR_W-1:0]];
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and buffered load results onto the single register-file write port.
module writeback_arbiter
    import riscv_definitions::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clk_en,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [REG_ADDR-1:0]   i_alu_rd,
    input  logic [DATA_WIDTH-1:0] i_alu_data,
    input  logic                  i_lsu_valid,
    output logic                  o_lsu_ready,
    input  logic [REG_ADDR-1:0]   i_lsu_rd,
    input  logic [DATA_WIDTH-1:0] i_lsu_data,
    output logic                  o_wr_reg_en,
    output logic [REG_ADDR-1:0]   o_write_register_addr,
    output logic [DATA_WIDTH-1:0] o_write_data,
    output logic                  o_busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             force_lsu;
    wb_req_t          fifo_head;
    wb_req_t          winner;
    wb_grant_e        grant;
    logic [CNT_W-1:0] starve_cnt;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (push),
        .i_push_data ({i_lsu_rd, i_lsu_data}),
        .i_pop       (pop),
        .o_head      (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty)
    );

    // Readies depend only on registered state and the enable, never on a valid.
    assign force_lsu   = (starve_cnt == CNT_W'(STARVE_LIMIT)) && !fifo_empty;
    assign o_alu_ready = i_clk_en && !force_lsu;
    assign o_lsu_ready = i_clk_en && !fifo_full;
    assign push        = i_lsu_valid && o_lsu_ready;
    assign pop         = (grant == GRANT_LSU);

    always_comb begin
        // NOTE: defaults first so no path through the block leaves a latch.
        grant  = GRANT_NONE;
        winner = fifo_head;
        if (i_clk_en) begin
            if (force_lsu) begin
                grant = GRANT_LSU;
            end else if (i_alu_valid) begin
                grant  = GRANT_ALU;
                winner = '{rd: i_alu_rd, data: i_alu_data};
            end else if (!fifo_empty) begin
                grant = GRANT_LSU;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_reg_en           <= 1'b0;
            o_write_register_addr <= '0;
            o_write_data          <= '0;
        end else if (i_clk_en) begin
            if (grant != GRANT_NONE) begin
                o_write_register_addr <= winner.rd;
                o_write_data          <= winner.data;
                o_wr_reg_en           <= (winner.rd != '0);
            end else begin
                o_wr_reg_en <= 1'b0;
            end
        end
    end

    // Counts cycles a waiting load head has lost; saturates so it stays forced.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
        end else if (i_clk_en) begin
            if (fifo_empty || pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    assign o_busy = !fifo_empty || o_wr_reg_en;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a scoreboard of expected register writes.
module tb_writeback_arbiter;
    import riscv_definitions::*;

    logic                  i_clk = 1'b0;
    logic                  i_rst_n;
    logic                  i_clk_en;
    logic                  i_alu_valid;
    logic                  o_alu_ready;
    logic [REG_ADDR-1:0]   i_alu_rd;
    logic [DATA_WIDTH-1:0] i_alu_data;
    logic                  i_lsu_valid;
    logic                  o_lsu_ready;
    logic [REG_ADDR-1:0]   i_lsu_rd;
    logic [DATA_WIDTH-1:0] i_lsu_data;
    logic                  o_wr_reg_en;
    logic [REG_ADDR-1:0]   o_write_register_addr;
    logic [DATA_WIDTH-1:0] o_write_data;
    logic                  o_busy;

    int checks   = 0;
    int failures = 0;

    wb_req_t exp_q [$];
    wb_req_t alu_beats [$];
    wb_req_t lsu_beats [$];
    int      lsu_stalls [$];
    int      alu_stalls;
    logic [DATA_WIDTH-1:0] regs [32] = '{default: '0};

    writeback_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .i_clk_en              (i_clk_en),
        .i_alu_valid           (i_alu_valid),
        .o_alu_ready           (o_alu_ready),
        .i_alu_rd              (i_alu_rd),
        .i_alu_data            (i_alu_data),
        .i_lsu_valid           (i_lsu_valid),
        .o_lsu_ready           (o_lsu_ready),
        .i_lsu_rd              (i_lsu_rd),
        .i_lsu_data            (i_lsu_data),
        .o_wr_reg_en           (o_wr_reg_en),
        .o_write_register_addr (o_write_register_addr),
        .o_write_data          (o_write_data),
        .o_busy                (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every asserted write must match the head of the scoreboard.
    always @(negedge i_clk) begin : monitor
        wb_req_t e;
        if (o_wr_reg_en === 1'b1) begin
            regs[o_write_register_addr] <= o_write_data;
            check("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("write_addr_data", {o_write_register_addr, o_write_data}, e);
            end
        end
    end

    task automatic run_alu();
        alu_stalls = 0;
        foreach (alu_beats[i]) begin
            int w = 0;
            i_alu_valid = 1'b1;
            i_alu_rd    = alu_beats[i].rd;
            i_alu_data  = alu_beats[i].data;
            @(negedge i_clk);
            while (!o_alu_ready && w < 50) begin
                w++;
                @(negedge i_clk);
            end
            alu_stalls += w;
            @(posedge i_clk);
            #1;
        end
        i_alu_valid = 1'b0;
    endtask

    task automatic run_lsu();
        lsu_stalls.delete();
        foreach (lsu_beats[i]) begin
            int w = 0;
            i_lsu_valid = 1'b1;
            i_lsu_rd    = lsu_beats[i].rd;
            i_lsu_data  = lsu_beats[i].data;
            @(negedge i_clk);
            while (!o_lsu_ready && w < 50) begin
                w++;
                @(negedge i_clk);
            end
            lsu_stalls.push_back(w);
            @(posedge i_clk);
            #1;
        end
        i_lsu_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 40) begin
            @(negedge i_clk);
            w++;
        end
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    task automatic alu_stream(input int n);
        alu_beats.delete();
        for (int i = 0; i < n; i++)
            alu_beats.push_back('{rd: REG_ADDR'(10 + i), data: 32'hA000_0000 + i});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        i_rst_n = 1'b0; i_clk_en = 1'b1;
        i_alu_valid = 1'b0; i_alu_rd = '0; i_alu_data = '0;
        i_lsu_valid = 1'b0; i_lsu_rd = '0; i_lsu_data = '0;
        #2;
        check("reset_wr_en", 64'(o_wr_reg_en), 64'd0);
        check("reset_addr_data", {o_write_register_addr, o_write_data}, 64'd0);
        check("reset_busy", 64'(o_busy), 64'd0);
        check("reset_lsu_ready", 64'(o_lsu_ready), 64'd1);

        // ALU write on the first edge after reset release, 1-cycle latency.
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        alu_beats = '{'{rd: 5'd1, data: 32'hDEAD_BEEF}};
        exp_q.push_back('{rd: 5'd1, data: 32'hDEAD_BEEF});
        run_alu();
        check("alu_first_edge_stalls", 64'(alu_stalls), 64'd0);
        @(negedge i_clk);
        check("alu_latency_wr_en", 64'(o_wr_reg_en), 64'd1);
        drain();

        // Back-to-back loads with ALU idle: push and pop share cycles.
        lsu_beats = '{'{rd: 5'd20, data: 32'h2020_0000}, '{rd: 5'd21, data: 32'h2121_0001},
                      '{rd: 5'd22, data: 32'h2222_0002}};
        foreach (lsu_beats[i]) exp_q.push_back(lsu_beats[i]);
        fork
            run_lsu();
            begin
                @(posedge i_clk);
                @(negedge i_clk);
                check("lsu_latency_no_early_write", 64'(o_wr_reg_en), 64'd0);
                check("lsu_pending_busy", 64'(o_busy), 64'd1);
            end
        join
        check("stream_stalls", {lsu_stalls[0][15:0], lsu_stalls[1][15:0], lsu_stalls[2][15:0]}, 64'd0);
        drain();

        // Starvation: ALU wins 5 edges (4 with the load waiting), then the load is forced.
        alu_stream(9);
        lsu_beats = '{'{rd: 5'd2, data: 32'hCAFE_BABE}};
        for (int i = 0; i < 5; i++) exp_q.push_back(alu_beats[i]);
        exp_q.push_back(lsu_beats[0]);
        for (int i = 5; i < 9; i++) exp_q.push_back(alu_beats[i]);
        fork run_alu(); run_lsu(); join
        check("starve_alu_stalls", 64'(alu_stalls), 64'd1);
        drain();
        check("readback_x2", 64'(regs[2]), 64'hCAFE_BABE);

        // Three loads against a busy ALU: third waits for the first pop.
        alu_stream(9);
        lsu_beats = '{'{rd: 5'd5, data: 32'h3333_0000}, '{rd: 5'd6, data: 32'h3333_0001},
                      '{rd: 5'd7, data: 32'h3333_0002}};
        for (int i = 0; i < 5; i++) exp_q.push_back(alu_beats[i]);
        exp_q.push_back(lsu_beats[0]);
        for (int i = 5; i < 9; i++) exp_q.push_back(alu_beats[i]);
        exp_q.push_back(lsu_beats[1]);
        exp_q.push_back(lsu_beats[2]);
        fork run_alu(); run_lsu(); join
        check("full_lsu_stalls", {lsu_stalls[0][15:0], lsu_stalls[1][15:0], lsu_stalls[2][15:0]},
              {16'd0, 16'd0, 16'd4});
        check("full_alu_stalls", 64'(alu_stalls), 64'd1);
        drain();

        // Write to x0 is acknowledged but suppressed.
        alu_beats = '{'{rd: 5'd0, data: 32'hFFFF_FFFF}};
        run_alu();
        check("x0_alu_stalls", 64'(alu_stalls), 64'd0);
        @(negedge i_clk);
        check("x0_wr_en", 64'(o_wr_reg_en), 64'd0);
        drain();
        check("readback_x0", 64'(regs[0]), 64'd0);

        // Reset with two queued loads and a pending ALU write.
        alu_beats = '{'{rd: 5'd12, data: 32'h1212_0000}, '{rd: 5'd13, data: 32'h1313_0000}};
        lsu_beats = '{'{rd: 5'd14, data: 32'h1414_0000}, '{rd: 5'd15, data: 32'h1515_0000}};
        exp_q.push_back(alu_beats[0]);
        fork run_alu(); run_lsu(); join
        #1;
        check("prereset_busy_full", {o_busy, o_lsu_ready, o_wr_reg_en}, 64'b101);
        i_rst_n = 1'b0;
        #1;
        check("midreset_wr_en", 64'(o_wr_reg_en), 64'd0);
        check("midreset_addr_data", {o_write_register_addr, o_write_data}, 64'd0);
        check("midreset_busy", 64'(o_busy), 64'd0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        check("postreset_state", {o_busy, o_lsu_ready, o_wr_reg_en}, 64'b010);
        drain();

        // Clock enable low for three edges with a load pending.
        lsu_beats = '{'{rd: 5'd25, data: 32'h5555_AAAA}};
        exp_q.push_back(lsu_beats[0]);
        run_lsu();
        i_clk_en = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            check("freeze_readies", {o_alu_ready, o_lsu_ready}, 64'd0);
            check("freeze_busy_wr_en", {o_busy, o_wr_reg_en}, 64'b10);
        end
        @(posedge i_clk);
        #1 i_clk_en = 1'b1;
        drain();
        check("readback_x25", 64'(regs[25]), 64'h5555_AAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
